// File: rtl/angle_entry_pkg.sv
// Shared types and constants for the push-button angle entry block.
// Holds the FSM state enum, cursor index constants, default angle limit
// and small BCD helper functions used by angle_key_entry.
package angle_entry_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EDIT = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] DIG_UNITS = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_HUNDS = 2'd2;

  localparam int MAX_ANGLE_DEF = 360;
  localparam int BCD_W         = 12;

  // Single BCD digit +1 with 9 -> 0 wrap.
  function automatic logic [3:0] bcd_inc(input logic [3:0] n);
    return (n == 4'd9) ? 4'd0 : n + 4'd1;
  endfunction

  // Single BCD digit -1 with 0 -> 9 wrap.
  function automatic logic [3:0] bcd_dec(input logic [3:0] n);
    return (n == 4'd0) ? 4'd9 : n - 4'd1;
  endfunction

  // Three-digit BCD image of a small non-negative integer (elaboration-time use).
  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    int h, t, u;
    h = (v / 100) % 10;
    t = (v / 10) % 10;
    u = v % 10;
    return {h[3:0], t[3:0], u[3:0]};
  endfunction

endpackage

// File: rtl/angle_key_entry_key_debounce.sv
// Purpose: 2-flop synchronizer, stability-count debounce and press pulse for one active-low key.
// Latency: press pulse 2 + DEBOUNCE_CYCLES + 1 cycles after the first stable raw low.
// Backpressure: none; the pulse is one cycle wide and is never held.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_vld
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          stable_dly_q, stable_dly_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Debounce: the stable level flips on the Nth consecutive differing sample; any agreement restarts.
  always_comb begin
    sync1_d      = key_n;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    cnt_d        = '0;
    stable_dly_d = stable_q;
    press_d      = stable_dly_q & ~stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers; everything resets to the released level so no event follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign press_vld = press_q;

endmodule

// File: rtl/angle_key_entry.sv
// Purpose: debounced 4-key BCD angle editor with serial BCD->binary commit (macro ANGLE_CLAMP_EN clamps instead of rejecting).
// Latency: edit events visible 1 cycle after the event; commit out_valid/out_err 4 cycles after the ok event.
// Backpressure: none; key events arriving during CONV/DONE are discarded.
module angle_key_entry
  import angle_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_ANGLE       = MAX_ANGLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_sel,
  input  logic              key_inc,
  input  logic              key_dec,
  input  logic              key_ok,
  output logic [BCD_W-1:0]  edit_bcd,
  output logic [1:0]        edit_digit,
  output logic              editing,
  output logic [8:0]        out_angle,
  output logic              out_valid,
  output logic              out_err
);

  localparam logic [9:0] MAX_A10 = 10'(MAX_ANGLE);
`ifdef ANGLE_CLAMP_EN
  localparam logic [8:0]       MAX_A9  = 9'(MAX_ANGLE);
  localparam logic [BCD_W-1:0] MAX_BCD = to_bcd(MAX_ANGLE);
`endif

  logic ev_sel, ev_inc, ev_dec, ev_ok;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (.clk(clk), .rst(rst), .key_n(key_sel), .press_vld(ev_sel));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (.clk(clk), .rst(rst), .key_n(key_inc), .press_vld(ev_inc));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (.clk(clk), .rst(rst), .key_n(key_dec), .press_vld(ev_dec));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ok  (.clk(clk), .rst(rst), .key_n(key_ok),  .press_vld(ev_ok));

  state_t           state_q, state_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [1:0]       digit_q, digit_d;
  logic [9:0]       acc_q, acc_d;
  logic [1:0]       step_q, step_d;
  logic [8:0]       angle_q, angle_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             editing_q, editing_d;

  logic             do_ok, do_sel, do_inc, do_dec;
  logic [3:0]       cur_nib, new_nib, conv_dig;
  logic [9:0]       acc_mac;

  // Priority ok > sel > inc > dec, plus digit selection for editing and conversion.
  always_comb begin
    do_ok  = ev_ok;
    do_sel = ev_sel & ~ev_ok;
    do_inc = ev_inc & ~ev_ok & ~ev_sel;
    do_dec = ev_dec & ~ev_ok & ~ev_sel & ~ev_inc;
    case (digit_q)
      DIG_UNITS: cur_nib = bcd_q[3:0];
      DIG_TENS:  cur_nib = bcd_q[7:4];
      default:   cur_nib = bcd_q[11:8];
    endcase
    new_nib = do_inc ? bcd_inc(cur_nib) : bcd_dec(cur_nib);
    case (step_q)
      2'd0:    conv_dig = bcd_q[11:8];
      2'd1:    conv_dig = bcd_q[7:4];
      default: conv_dig = bcd_q[3:0];
    endcase
    acc_mac = {acc_q[6:0], 3'b000} + {acc_q[8:0], 1'b0} + {6'd0, conv_dig};
  end

  // FSM next-state: editing, serial multiply-accumulate conversion, commit / reject.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    digit_d = digit_q;
    acc_d   = acc_q;
    step_d  = step_q;
    angle_d = angle_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (do_sel) begin
          state_d = EDIT;
          digit_d = DIG_UNITS;
        end
      end
      EDIT: begin
        if (do_ok) begin
          state_d = CONV;
          acc_d   = '0;
          step_d  = 2'd0;
        end else if (do_sel) begin
          digit_d = (digit_q == DIG_HUNDS) ? DIG_UNITS : digit_q + 2'd1;
        end else if (do_inc || do_dec) begin
          case (digit_q)
            DIG_UNITS: bcd_d[3:0]  = new_nib;
            DIG_TENS:  bcd_d[7:4]  = new_nib;
            default:   bcd_d[11:8] = new_nib;
          endcase
        end
      end
      CONV: begin
        acc_d  = acc_mac;
        step_d = step_q + 2'd1;
        if (step_q == 2'd2) begin
          if (acc_mac <= MAX_A10) begin
            angle_d = acc_mac[8:0];
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
`ifdef ANGLE_CLAMP_EN
            angle_d = MAX_A9;
            bcd_d   = MAX_BCD;
            valid_d = 1'b1;
            state_d = DONE;
`else
            err_d   = 1'b1;
            state_d = EDIT;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    editing_d = (state_d == EDIT);
  end

  // Single register bank for FSM state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      digit_q   <= DIG_UNITS;
      acc_q     <= '0;
      step_q    <= 2'd0;
      angle_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      editing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      digit_q   <= digit_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      angle_q   <= angle_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      editing_q <= editing_d;
    end
  end

  assign edit_bcd   = bcd_q;
  assign edit_digit = digit_q;
  assign editing    = editing_q;
  assign out_angle  = angle_q;
  assign out_valid  = valid_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_angle_key_entry.sv
// Bench for angle_key_entry with DEBOUNCE_CYCLES=4: directed scenarios plus random key presses
// checked against a decimal-arithmetic model of the entry rules.
module tb_angle_key_entry;

  localparam int DB = 4;
  localparam logic [3:0] K_SEL = 4'b0001;
  localparam logic [3:0] K_INC = 4'b0010;
  localparam logic [3:0] K_DEC = 4'b0100;
  localparam logic [3:0] K_OK  = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  keys_n = 4'hF;
  logic [11:0] edit_bcd;
  logic [1:0]  edit_digit;
  logic        editing;
  logic [8:0]  out_angle;
  logic        out_valid;
  logic        out_err;

  always #5 clk = ~clk;

  angle_key_entry #(.DEBOUNCE_CYCLES(DB), .MAX_ANGLE(360)) dut (
    .clk(clk), .rst(rst),
    .key_sel(keys_n[0]), .key_inc(keys_n[1]), .key_dec(keys_n[2]), .key_ok(keys_n[3]),
    .edit_bcd(edit_bcd), .edit_digit(edit_digit), .editing(editing),
    .out_angle(out_angle), .out_valid(out_valid), .out_err(out_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: digits, cursor, edit mode, committed angle
  int m_dig[3];
  int m_cur;
  bit m_edit;
  int m_angle;
  int exp_vld, exp_err;

  // observations of the last press
  int p_vld, p_err, p_vld_edge, p_err_edge, p_chg_edge, p_fall_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_bcd();
    return m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0];
  endfunction

  task automatic model_reset();
    m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 0;
    m_cur = 0; m_edit = 0; m_angle = 0;
  endtask

  task automatic model_apply(input logic [3:0] mask);
    int v;
    exp_vld = 0; exp_err = 0;
    if (!m_edit) begin
      if (mask[3]) begin
        // ok ignored while idle; it also blocks sel
      end else if (mask[0]) begin
        m_edit = 1; m_cur = 0;
      end
    end else if (mask[3]) begin
      v = m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
      if (v <= 360) begin
        m_angle = v; exp_vld = 1; m_edit = 0;
      end else begin
`ifdef ANGLE_CLAMP_EN
        m_angle = 360; m_dig[2] = 3; m_dig[1] = 6; m_dig[0] = 0;
        exp_vld = 1; m_edit = 0;
`else
        exp_err = 1;
`endif
      end
    end else if (mask[0]) begin
      m_cur = (m_cur + 1) % 3;
    end else if (mask[1]) begin
      m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
    end else if (mask[2]) begin
      m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
    end
  endtask

  // hold the keys low for 12 cycles, release for 10, record what the outputs did
  task automatic press(input logic [3:0] mask);
    logic [11:0] b0;
    logic [1:0]  d0;
    logic        ed_prev;
    b0 = edit_bcd; d0 = edit_digit; ed_prev = editing;
    p_vld = 0; p_err = 0; p_vld_edge = -1; p_err_edge = -1; p_chg_edge = -1; p_fall_edge = -1;
    keys_n = ~mask;
    for (int i = 1; i <= 22; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin p_vld++; if (p_vld_edge < 0) p_vld_edge = i; end
      if (out_err === 1'b1) begin p_err++; if (p_err_edge < 0) p_err_edge = i; end
      if (p_chg_edge < 0 && (edit_bcd !== b0 || edit_digit !== d0)) p_chg_edge = i;
      if (p_fall_edge < 0 && ed_prev === 1'b1 && editing === 1'b0) p_fall_edge = i;
      ed_prev = editing;
      if (i == 12) keys_n = 4'hF;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bcd"}, edit_bcd, exp_bcd());
    chk({tag, ".cursor"}, edit_digit, m_cur);
    chk({tag, ".editing"}, editing, m_edit);
    chk({tag, ".angle"}, out_angle, m_angle);
    chk({tag, ".valid_pulses"}, p_vld, exp_vld);
    chk({tag, ".err_pulses"}, p_err, exp_err);
  endtask

  task automatic step(input logic [3:0] mask, input string tag);
    model_apply(mask);
    press(mask);
    check_all(tag);
  endtask

  task automatic set_digits(input int h, input int t, input int u);
    int tgt[3];
    tgt[0] = u; tgt[1] = t; tgt[2] = h;
    for (int pos = 0; pos < 3; pos++) begin
      while (m_cur != pos) step(K_SEL, "set.sel");
      while (m_dig[pos] != tgt[pos]) step(K_INC, "set.inc");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; keys_n = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit quiet;
    logic [11:0] b0;
    logic [3:0] m;
    int r, vseen;

    // reset values
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.bcd", edit_bcd, 0);
    chk("reset.cursor", edit_digit, 0);
    chk("reset.editing", editing, 0);
    chk("reset.angle", out_angle, 0);
    chk("reset.valid", out_valid, 0);
    chk("reset.err", out_err, 0);
    rst = 1'b0;

    // bounce on inc, then a clean hold
    step(K_SEL, "enter");
    b0 = edit_bcd; quiet = 1;
    for (int i = 0; i < 20; i++) begin
      keys_n[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (edit_bcd !== b0) quiet = 0;
    end
    chk("bounce.quiet", quiet, 1);
    keys_n[1] = 1'b0; lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (lat < 0 && edit_bcd !== b0) lat = i;
    end
    keys_n[1] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("bounce.latency", lat, 2 + DB + 1 + 1);
    m_dig[0] = (m_dig[0] + 1) % 10;
    exp_vld = 0; exp_err = 0; p_vld = 0; p_err = 0;
    check_all("bounce");

    // edit 143 and commit
    do_reset();
    @(posedge clk); #1;
    step(K_SEL, "e143.sel");
    repeat (3) step(K_INC, "e143.inc_u");
    step(K_SEL, "e143.sel");
    repeat (4) step(K_INC, "e143.inc_t");
    step(K_SEL, "e143.sel");
    step(K_INC, "e143.inc_h");
    step(K_OK, "e143.ok");
    chk("commit.angle143", out_angle, 143);
    chk("commit.bcd143", edit_bcd, 12'h143);
    chk("commit.valid_edge", p_vld_edge, 2 + DB + 1 + 4);
    chk("commit.editing_fall_edge", p_fall_edge, 2 + DB + 1 + 1);

    // wrap
    step(K_SEL, "wrap.enter");
    while (m_dig[0] != 0) step(K_DEC, "wrap.to0");
    step(K_DEC, "wrap.dec");
    chk("wrap.units9", edit_bcd[3:0], 9);
    step(K_INC, "wrap.inc");
    chk("wrap.units0", edit_bcd[3:0], 0);
    repeat (3) step(K_SEL, "wrap.sel");
    chk("wrap.cursor0", edit_digit, 0);

    // out of range
    set_digits(9, 9, 9);
    step(K_OK, "oor.ok");
`ifdef ANGLE_CLAMP_EN
    chk("oor.angle", out_angle, 360);
    chk("oor.bcd", edit_bcd, 12'h360);
    chk("oor.valid", p_vld, 1);
`else
    chk("oor.err", p_err, 1);
    chk("oor.angle_kept", out_angle, 143);
    chk("oor.editing", editing, 1);
    chk("oor.valid", p_vld, 0);
`endif

    // simultaneous ok + inc
    if (!m_edit) step(K_SEL, "sim.enter");
    set_digits(3, 5, 9);
    while (m_cur != 0) step(K_SEL, "sim.cur");
    step(K_OK | K_INC, "sim.okinc");
    chk("sim.angle", out_angle, 359);
    chk("sim.bcd", edit_bcd, 12'h359);

    // reset during conversion
    step(K_SEL, "rc.enter");
    set_digits(2, 0, 0);
    keys_n[3] = 1'b0; vseen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) vseen++;
      if (i == 9) rst = 1'b1;
    end
    chk("rc.angle", out_angle, 0);
    chk("rc.bcd", edit_bcd, 0);
    chk("rc.editing", editing, 0);
    chk("rc.cursor", edit_digit, 0);
    rst = 1'b0; keys_n = 4'hF; model_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) vseen++;
    end
    chk("rc.no_valid", vseen, 0);

    // random key sequence
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) m = K_SEL;
      else if (r <= 5) m = K_INC;
      else if (r <= 7) m = K_DEC;
      else if (r == 8) m = K_OK;
      else m = 4'($urandom_range(1, 15));
      step(m, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
